usr_cmd_sequencer: RTL and testbench
====================================

Name: usr_cmd_sequencer

Overview:
- Command sequencer directly upstream of the 4-bit universal shift register.
- Accepts one command at a time over a valid/ready interface: HOLD, SHIFT-LEFT, SHIFT-RIGHT or LOAD.
- Converts each command into a cycle-accurate stream of sel / serial_in / inp drives, so software-level operations such as "shift in these 5 bits MSB-first" become single transactions.
- Reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 4, parallel width of the downstream shift register (width of inp / cmd_data load field).
- PAT_W, 8, serial bit-pattern width; maximum bits shifted per command.
- CNT_W, 4, width of cmd_count; must satisfy 2**CNT_W > PAT_W.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; combinational, equal to (state == IDLE).
- cmd_op  in  2  00 HOLD, 01 SHL, 10 SHR, 11 LOAD (same encoding as downstream sel).
- cmd_count  in  CNT_W  cycles for HOLD, or bits to shift for SHL/SHR; ignored for LOAD.
- cmd_data  in  PAT_W  serial pattern, consumed LSB first; for LOAD, bits [WIDTH-1:0] are the parallel word.
- sel  out  2  to shift register sel; registered.
- serial_in  out  1  to shift register serial_in; registered.
- inp  out  WIDTH  to shift register inp; registered.
- busy  out  1  high while state == EXEC; registered.
- done  out  1  one-cycle completion pulse; registered.

Behaviour:
- The clock is clk, a single rising-edge clock. The reset is reset, asynchronous and active-high.
- Reset, asynchronous on assertion, sets:
  - state = IDLE
  - sel = 00, serial_in = 0, inp = 0
  - busy = 0, done = 0
  - internal count and pattern registers = 0
- Commands presented while reset is high are ignored.
- States:
  - IDLE: sel = 00 (downstream holds).
  - EXEC: drive beats in progress.
- Accept: a command is accepted at the edge where cmd_valid && cmd_ready (edge T). cmd_* must be stable only at that edge; they are latched there.
- Effective count N:
  - N = min(cmd_count, PAT_W) for SHL/SHR/HOLD.
  - N = 1 for LOAD.
- N >= 1:
  - At edge T, go to EXEC and present beat 1 on the registered outputs.
  - Beat k (k = 1..N) is visible during the cycle after edge T+k-1 and is captured downstream at edge T+k.
  - At edge T+N, state returns to IDLE, sel = 00, busy = 0 and done = 1 for exactly one cycle.
  - Total latency from accept to done-visible: N+1 edges.
- N = 0 (SHL/SHR/HOLD with count 0): stay in IDLE and keep sel = 00; done = 1 in the cycle after edge T. There are no drive beats.
- Beat contents:
  - SHL/SHR: sel = cmd_op; serial_in on beat k = cmd_data[k-1]; pattern shifted right internally each beat; inp = 0.
  - HOLD: sel = 00, serial_in = 0 for N beats (timed wait, busy high).
  - LOAD: sel = 11, inp = cmd_data[WIDTH-1:0], serial_in = 0 for one beat.
- Outside EXEC: inp = 0 and serial_in = 0.
- Back-to-back commands: cmd_ready is 1 again in the cycle done is high, so a command accepted at edge T+N+1 drives its first beat after that edge. There is a minimum one idle (sel = 00) cycle between commands.
- cmd_valid is ignored while busy. cmd_valid may be deasserted without acceptance; no command is dropped once accepted.
- Reset during EXEC aborts the command immediately (asynchronous). No done pulse is produced for the aborted command.
- Counter width: the internal beat counter is CNT_W bits. The clamp prevents any wrap.

Decomposition:
- Shared package usr_pkg holds:
  - op enum constants OP_HOLD = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_LOAD = 2'b11, so sequencer and shift register share one encoding;
  - state encoding ST_IDLE / ST_EXEC;
  - default widths.
- No sub-module; a single FSM + counter + pattern register is the natural size.
- The top-level integration (sequencer feeding the shift register) is a separate wrapper, outside this block.

Test Plan:
- Reset: assert reset mid-cycle with outputs nonzero -> sel = 00, inp = 0, busy = 0, done = 0 without waiting for clk; cmd_ready = 1 after release.
- LOAD: cmd_op = 11, cmd_data = 8'h0A -> one beat sel = 11, inp = 4'hA; done after 2 edges; downstream out = 4'hA.
- SHL: from out = 4'h0, cmd_op = 01, count = 3, data = 8'b101 -> beats serial_in 1, 0, 1 with sel = 01; downstream out = 4'b0101; done at edge T+3.
- SHR clamp: count = 15, data = 8'hFF -> exactly 8 beats sel = 10, serial_in = 1; out = 4'hF; busy high for 8 cycles.
- Count 0 and back-to-back: SHL count 0 -> done next cycle, no sel activity; then LOAD 4'h5 then SHR count 1 data 0 presented continuously -> second accepted the cycle done pulses; out = 4'h2.
- Reset abort: SHL count 6 reset at beat 3 -> outputs idle immediately, no done pulse; a new LOAD after release executes normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the command sequencer and the downstream shift register.
package usr_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/usr_cmd_sequencer.sv
// Turns one HOLD/SHL/SHR/LOAD command into a cycle-accurate stream of
// sel/serial_in/inp drives for the universal shift register, then pulses done.
module usr_cmd_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [PAT_W-1:0] cmd_data,
  output logic [1:0]       sel,
  output logic             serial_in,
  output logic [WIDTH-1:0] inp,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] PAT_MAX = CNT_W'(PAT_W);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic [1:0]       op_q, op_n;
  logic [1:0]       sel_n;
  logic             ser_n, busy_n, done_n;
  logic [WIDTH-1:0] inp_n;
  logic [CNT_W-1:0] n_eff;

  assign cmd_ready = (state == ST_IDLE);

  // LOAD is always a single beat; other ops are clamped to the pattern width.
  always_comb begin
    if (cmd_op == OP_LOAD)     n_eff = ONE;
    else if (cmd_count > PAT_MAX) n_eff = PAT_MAX;
    else                       n_eff = cmd_count;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    op_n    = op_q;
    sel_n   = OP_HOLD;
    ser_n   = 1'b0;
    inp_n   = '0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (n_eff == '0) begin
            done_n = 1'b1;
          end else begin
            // Beat 1 goes out on the accept edge; cnt holds the beats still to come.
            state_n = ST_EXEC;
            busy_n  = 1'b1;
            op_n    = cmd_op;
            sel_n   = cmd_op;
            cnt_n   = n_eff - ONE;
            pat_n   = cmd_data >> 1;
            if (is_shift(cmd_op)) ser_n = cmd_data[0];
            if (cmd_op == OP_LOAD) inp_n = cmd_data[WIDTH-1:0];
          end
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          busy_n = 1'b1;
          sel_n  = op_q;
          cnt_n  = cnt - ONE;
          pat_n  = pat >> 1;
          if (is_shift(op_q)) ser_n = pat[0];
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pat       <= '0;
      op_q      <= OP_HOLD;
      sel       <= OP_HOLD;
      serial_in <= 1'b0;
      inp       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pat       <= pat_n;
      op_q      <= op_n;
      sel       <= sel_n;
      serial_in <= ser_n;
      inp       <= inp_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench for usr_cmd_sequencer with a behavioural downstream shift register.
module tb_usr_cmd_sequencer;
  localparam int WIDTH = 4;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [PAT_W-1:0] cmd_data = '0;
  logic [1:0]       sel;
  logic             serial_in;
  logic [WIDTH-1:0] inp;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  logic [WIDTH-1:0] dout = '0;

  usr_cmd_sequencer #(.WIDTH(WIDTH), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .sel(sel), .serial_in(serial_in), .inp(inp), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register: SHL fills at bit 0, SHR at the MSB.
  always @(posedge clk) begin
    case (sel)
      2'b01: dout <= {dout[WIDTH-2:0], serial_in};
      2'b10: dout <= {serial_in, dout[WIDTH-1:1]};
      2'b11: dout <= inp;
      default: dout <= dout;
    endcase
    if (done) done_seen <= done_seen + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic [PAT_W-1:0] data;
    int               n;
    logic [1:0]       esel;
    logic [WIDTH-1:0] einp;
    logic [PAT_W-1:0] ebits;
    logic [WIDTH-1:0] eout;
  } vec_t;

  vec_t vt[8];

  task automatic run_cmd(input vec_t v);
    @(negedge clk);
    cmd_op = v.op; cmd_count = v.count; cmd_data = v.data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.n == 0) begin
      chk("n0_done", done, 1);
      chk("n0_sel", sel, 0);
      chk("n0_busy", busy, 0);
      chk("n0_ready", cmd_ready, 1);
    end else begin
      for (int k = 1; k <= v.n; k++) begin
        chk("beat_busy", busy, 1);
        chk("beat_sel", sel, v.esel);
        chk("beat_ser", serial_in, v.ebits[k-1]);
        chk("beat_inp", inp, v.einp);
        chk("beat_nodone", done, 0);
        @(posedge clk); #1;
      end
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_sel", sel, 0);
      chk("end_ready", cmd_ready, 1);
    end
    @(posedge clk); #1;
    chk("done_pulse_one", done, 0);
    chk("dout", dout, v.eout);
  endtask

  initial begin
    //        op     cnt   data          n  esel   einp   ebits         eout
    vt[0] = '{2'b01, 4'd3, 8'b0000_0101, 3, 2'b01, 4'h0, 8'b0000_0101, 4'b0101};
    vt[1] = '{2'b11, 4'd7, 8'h0A,        1, 2'b11, 4'hA, 8'h00,        4'hA};
    vt[2] = '{2'b10, 4'd15, 8'hFF,       8, 2'b10, 4'h0, 8'hFF,        4'hF};
    vt[3] = '{2'b00, 4'd3, 8'hFF,        3, 2'b00, 4'h0, 8'h00,        4'hF};
    vt[4] = '{2'b01, 4'd0, 8'hFF,        0, 2'b00, 4'h0, 8'h00,        4'hF};
    vt[5] = '{2'b01, 4'd8, 8'h1F,        8, 2'b01, 4'h0, 8'h1F,        4'h8};
    vt[6] = '{2'b10, 4'd2, 8'b0000_0010, 2, 2'b10, 4'h0, 8'b0000_0010, 4'hA};
    vt[7] = '{2'b00, 4'd9, 8'hAA,        8, 2'b00, 4'h0, 8'h00,        4'hA};

    // Reset state, and commands presented during reset are ignored.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h0F;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_inp", inp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ser", serial_in, 0);
    @(negedge clk);
    cmd_valid = 1'b0; reset = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run_cmd(vt[i]);

    // Back-to-back: LOAD 5 then SHR 1 data 0 with valid held high.
    @(negedge clk);
    cmd_op = 2'b11; cmd_count = 4'd0; cmd_data = 8'h05; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'b10; cmd_count = 4'd1; cmd_data = 8'h00;
    chk("b2b_load_sel", sel, 2'b11);
    chk("b2b_load_inp", inp, 4'h5);
    chk("b2b_busy_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("b2b_done1", done, 1);
    chk("b2b_ready_in_done", cmd_ready, 1);
    chk("b2b_idle_gap", sel, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("b2b_shr_sel", sel, 2'b10);
    chk("b2b_shr_ser", serial_in, 0);
    chk("b2b_shr_nodone", done, 0);
    @(posedge clk); #1;
    chk("b2b_done2", done, 1);
    @(posedge clk); #1;
    chk("b2b_dout", dout, 4'h2);

    // Reset abort in the middle of a 6-beat SHL.
    @(negedge clk);
    cmd_op = 2'b01; cmd_count = 4'd6; cmd_data = 8'h3F; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_beat3_busy", busy, 1);
    chk("abort_beat3_sel", sel, 2'b01);
    done_seen = 0;
    #1 reset = 1'b1;
    #1;
    chk("abort_sel", sel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ser", serial_in, 0);
    chk("abort_done", done, 0);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_seen, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_idle_busy", busy, 0);

    run_cmd('{2'b11, 4'd0, 8'hC6, 1, 2'b11, 4'h6, 8'h00, 4'h6});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
